// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter sharing one block memory between a data cache
// (port 0, read/write) and an instruction cache (port 1, read-only).
// Optional feature: define MEM_ARBITER_RR_EN for round-robin arbitration of
// simultaneous requests; without it port 0 always wins a tie.
module mem_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              p0_read,
    input  logic              p0_write,
    input  logic [ADDR_W-1:0] p0_address,
    input  logic [DATA_W-1:0] p0_writedata,
    output logic [DATA_W-1:0] p0_readdata,
    output logic              p0_busywait,
    input  logic              p1_read,
    input  logic [ADDR_W-1:0] p1_address,
    output logic [DATA_W-1:0] p1_readdata,
    output logic              p1_busywait,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_busywait
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] GNT0  = 3'd1;
    localparam logic [2:0] GNT1  = 3'd2;
    localparam logic [2:0] DONE0 = 3'd3;
    localparam logic [2:0] DONE1 = 3'd4;

    logic [2:0] state;
    logic [2:0] next_state;
    logic       p0_req;
    logic       p1_first;
    logic       gnt_write;

    assign p0_req = p0_read | p0_write;

`ifdef MEM_ARBITER_RR_EN
    logic rr_ptr;

    // Pointer favours the port that was not just served, so a tie alternates.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            rr_ptr <= 1'b0;
        end else if (state == DONE0) begin
            rr_ptr <= 1'b1;
        end else if (state == DONE1) begin
            rr_ptr <= 1'b0;
        end
    end

    assign p1_first = rr_ptr;
`else
    assign p1_first = 1'b0;
`endif

    // Next-state selection: arbitration only happens from IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (p0_req && !(p1_read && p1_first)) begin
                    next_state = GNT0;
                end else if (p1_read) begin
                    next_state = GNT1;
                end else begin
                    next_state = IDLE;
                end
            end
            GNT0:    next_state = mem_busywait ? GNT0 : DONE0;
            GNT1:    next_state = mem_busywait ? GNT1 : DONE1;
            DONE0:   next_state = IDLE;
            DONE1:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Grant state register; reset aborts any transaction in flight.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Remember whether the port 0 grant began as a write, so a request that
    // is withdrawn mid-grant still completes with the right capture rule.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            gnt_write <= 1'b0;
        end else if (state == IDLE && next_state == GNT0) begin
            gnt_write <= p0_write;
        end
    end

    // Capture returned blocks on the edge that leaves GNTn; writes leave
    // p0_readdata untouched.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            p0_readdata <= '0;
            p1_readdata <= '0;
        end else begin
            if (state == GNT0 && !mem_busywait && !gnt_write) begin
                p0_readdata <= mem_readdata;
            end
            if (state == GNT1 && !mem_busywait) begin
                p1_readdata <= mem_readdata;
            end
        end
    end

    // Memory side follows only the port selected by the registered grant.
    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        if (state == GNT0) begin
            mem_read      = p0_read & ~p0_write;
            mem_write     = p0_write;
            mem_address   = p0_address;
            mem_writedata = p0_writedata;
        end else if (state == GNT1) begin
            mem_read      = p1_read;
            mem_address   = p1_address;
        end
    end

    // A requesting port stalls everywhere except its own completion cycle.
    always_comb begin
        p0_busywait = p0_req && (state != DONE0);
        p1_busywait = p1_read && (state != DONE1);
    end

endmodule
